// File: rtl/cdb_arbiter_if.sv
// Common data bus arbiter port bundle: producer request channels plus the
// registered CDB broadcast they feed.
interface cdb_arbiter_if #(
    parameter int ROB   = 2,
    parameter int WIDTH = 31,
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]           req_valid;
    logic [N_REQ-1:0]           req_ready;
    logic [N_REQ*(ROB+1)-1:0]   req_rob;
    logic [N_REQ*(WIDTH+1)-1:0] req_result;
    logic                       cdb_valid;
    logic [ROB:0]               cdb_rob;
    logic [WIDTH:0]             cdb_result;
    logic [N_REQ-1:0]           cdb_src;

    modport master (
        output req_valid, req_rob, req_result,
        input  req_ready, cdb_valid, cdb_rob, cdb_result, cdb_src
    );

    modport slave (
        input  req_valid, req_rob, req_result,
        output req_ready, cdb_valid, cdb_rob, cdb_result, cdb_src
    );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin CDB arbiter: one producer accepted per cycle, its {tag, result}
// registered onto the broadcast bus one cycle later; flush kills new grants.
module cdb_lane #(
    parameter int ROB   = 2,
    parameter int WIDTH = 31
) (
    input  logic           sel,
    input  logic [ROB:0]   rob,
    input  logic [WIDTH:0] result,
    output logic [ROB:0]   rob_o,
    output logic [WIDTH:0] result_o
);
    assign rob_o    = sel ? rob    : '0;
    assign result_o = sel ? result : '0;
endmodule

module cdb_arbiter #(
    parameter int ROB   = 2,
    parameter int WIDTH = 31,
    parameter int N_REQ = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    cdb_arbiter_if.slave bus
);
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef struct packed {
        logic [ROB:0]   rob;
        logic [WIDTH:0] result;
    } bcast_t;

    logic [PW-1:0]                ptr, ptr_nxt, gidx;
    logic [N_REQ-1:0]             hi, grant, src_q;
    logic                         xfer, vld_q;
    logic [N_REQ-1:0][ROB:0]      lane_rob;
    logic [N_REQ-1:0][WIDTH:0]    lane_res;
    bcast_t                       sel, bc_q;

    // Two-pass search: lowest requester at/above ptr, else lowest overall (wrap).
    always_comb begin
        hi    = '0;
        grant = '0;
        gidx  = '0;
        for (int i = 0; i < N_REQ; i++)
            hi[i] = bus.req_valid[i] && (PW'(i) >= ptr);
        if (|hi) begin
            for (int i = N_REQ-1; i >= 0; i--)
                if (hi[i]) gidx = PW'(i);
        end else begin
            for (int i = N_REQ-1; i >= 0; i--)
                if (bus.req_valid[i]) gidx = PW'(i);
        end
        if ((|bus.req_valid) && !flush && !reset)
            grant[gidx] = 1'b1;
    end

    assign xfer    = |grant;
    assign ptr_nxt = (gidx == PW'(N_REQ-1)) ? '0 : gidx + PW'(1);

    for (genvar g = 0; g < N_REQ; g++) begin : g_lane
        cdb_lane #(.ROB(ROB), .WIDTH(WIDTH)) u_lane (
            .sel      (grant[g]),
            .rob      (bus.req_rob[g*(ROB+1) +: ROB+1]),
            .result   (bus.req_result[g*(WIDTH+1) +: WIDTH+1]),
            .rob_o    (lane_rob[g]),
            .result_o (lane_res[g])
        );
    end

    // Grant is one-hot, so an OR across gated lanes is the winner's payload.
    always_comb begin
        sel = '0;
        for (int i = 0; i < N_REQ; i++) begin
            sel.rob    = sel.rob    | lane_rob[i];
            sel.result = sel.result | lane_res[i];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr   <= '0;
            vld_q <= 1'b0;
            src_q <= '0;
            bc_q  <= '0;
        end else begin
            vld_q <= xfer;
            src_q <= grant;
            if (xfer) begin
                ptr  <= ptr_nxt;
                bc_q <= sel;
            end
        end
    end

    assign bus.req_ready  = grant;
    assign bus.cdb_valid  = vld_q;
    assign bus.cdb_rob    = bc_q.rob;
    assign bus.cdb_result = bc_q.result;
    assign bus.cdb_src    = src_q;
endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Arbitrates the common data bus (CDB) among N_REQ functional-unit result producers, e.g. ALU, branch, multiplier and load.
- Grants at most one producer per cycle.
- Registers the winner's {robEntry, result} onto the CDB broadcast that the ROB rename buffer, ROB and reservation stations consume.
- Uses round-robin fairness and kills in-flight broadcasts on a misprediction flush.

Parameters:
- ROB, 2, MSB index of ROB entry tag (tag width ROB+1).
- WIDTH, 31, MSB index of result data (data width WIDTH+1).
- N_REQ, 4, number of requesting functional units (2..8).

Ports:
- clk  in  1  clock, all state on posedge.
- reset  in  1  asynchronous active-high reset.
- flush  in  1  pipeline flush (branch mispredict); kills grants and the pending broadcast.
- req_valid  in  N_REQ  per-unit result-ready request.
- req_rob  in  N_REQ*(ROB+1)  packed ROB tags; unit i occupies bits [i*(ROB+1) +: ROB+1].
- req_result  in  N_REQ*(WIDTH+1)  packed results; same packing.
- req_ready  out  N_REQ  one-hot grant/accept, combinational, same cycle.
- cdb_valid  out  1  broadcast valid; drives commonDataBus.validBroadcast at top level.
- cdb_rob  out  ROB+1  broadcast ROB entry; drives robEntry.
- cdb_result  out  WIDTH+1  broadcast data; drives result.
- cdb_src  out  N_REQ  one-hot id of the unit that produced the current broadcast (debug/perf).

Behaviour:
- Handshake is valid/ready. A unit asserts req_valid with stable req_rob/req_result until it samples req_ready=1 at a posedge.
  - Transfer occurs on a cycle where req_valid[i] & req_ready[i].
  - A unit must not drop req_valid before it is accepted, except on flush.
- Grant (combinational):
  - req_ready = 0 when flush=1 or reset=1.
  - Otherwise the first asserted req_valid at or after index ptr, searching upward with wrap N_REQ-1 -> 0, gets req_ready=1.
  - req_ready is always one-hot or zero. It never asserts for a unit whose req_valid=0.
- Pointer: ptr is a $clog2(N_REQ)-bit register.
  - On a transfer from unit i, ptr <= (i+1) mod N_REQ. For non-power-of-2 N_REQ, ptr = N_REQ-1 wraps to 0, never to N_REQ.
  - No transfer: ptr holds.
- Broadcast register: latency is 1 cycle from acceptance to CDB.
  - On a posedge with a transfer from unit i: cdb_valid<=1, cdb_rob<=req_rob[i], cdb_result<=req_result[i], cdb_src<=onehot(i).
  - On a posedge with no transfer: cdb_valid<=0, cdb_src<=0. cdb_rob and cdb_result hold their last values (don't-care while invalid).
  - Throughput is one broadcast per cycle. Back-to-back grants to different or the same unit are allowed.
- Flush at a posedge: cdb_valid<=0, cdb_src<=0, no transfer, ptr holds.
  - A broadcast already on the CDB in the flush cycle is visible that cycle. Downstream qualifies it with flush itself.
  - Requesters discard their pending results on flush.
- Reset (async, any time including mid-broadcast):
  - cdb_valid=0, cdb_rob=0, cdb_result=0, cdb_src=0, ptr=0, req_ready=0 while reset=1.
  - First grant after deassert goes to the lowest-indexed valid requester.
- Starvation bound: a continuously requesting unit is granted within N_REQ cycles.
- No duplicate-tag checking; producers guarantee unique ROB tags in flight.
- Assertions for the bench:
  - req_ready is onehot0.
  - No req_ready without req_valid.
  - cdb_valid implies cdb_src is onehot.

Test Plan:
- Reset released, req_valid=4'b0100, req_rob[2]=3'd5, req_result[2]=32'hDEADBEEF -> req_ready=4'b0100 the same cycle; next cycle cdb_valid=1, cdb_rob=5, cdb_result=DEADBEEF, cdb_src=4'b0100; ptr=3.
- All four units request continuously from ptr=0 -> grants in order 0,1,2,3,0. cdb_valid is high every cycle. cdb_src sequence is 0001,0010,0100,1000,0001.
- ptr=3, req_valid=4'b0011 -> wrap search grants unit 0, then unit 1 next cycle; no cycle is granted to an idle unit.
- Unit 1 grant cycle coincides with flush=1, req_valid=4'b0010 -> req_ready=0, next cycle cdb_valid=0, ptr unchanged. Flush deasserts with the unit re-requesting tag 3 -> granted, cdb_rob=3 one cycle later.
- reset pulsed asynchronously mid-cycle while cdb_valid=1 -> cdb_valid, cdb_rob, cdb_result and cdb_src go to 0 immediately without a clock edge. After release, req_valid=4'b1010 grants unit 1.
- N_REQ=3 build, ptr=2, all request -> grants 2,0,1 and ptr never equals 3.
